pipelined_decode: RTL and testbench
===================================

PIPELINED_DECODE -- requirements
Module: pipelined_decode

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction and PC width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter HAZARD_EN, default 1; 1 enables load-use bubble insertion.
REQ-004 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports in_valid in 1, in_ready out 1, instr in INSTR_W, pc in INSTR_W: fetch-side handshake.
REQ-008 SHALL have port flush  in  1  discard the registered instruction.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1: execute-side handshake.
REQ-010 SHALL have registered field outputs: op[5:0], funct[5:0], rs/rt/rd[REG_AW], imm[15:0], imm_ext[INSTR_W] sign-extended, addr[25:0], pc_out[INSTR_W].
REQ-011 SHALL have registered control outputs: alu_src, alu_ctrl[2:0], reg_dst[1:0] (0 rt, 1 rd, 2 r31), reg_write, mem_write, mem_to_reg, branch_eq, branch_ne, jump, jump_link, jump_reg, illegal.
REQ-012 SHALL have port bubble_count  out  CNT_W  count of inserted load-use bubbles.

Function
REQ-013 SHALL decode LW, SW, BEQ, BNE, ADDI, XORI, J, JAL and R-type ADD, SUB, SLT, JR.
REQ-014 SHALL assert illegal for any other op/funct, with reg_write, mem_write, branch_*, jump* all 0.
REQ-015 SHALL load the output register when in_valid && in_ready; latency instr -> out_valid is 1 cycle.
REQ-016 SHALL drive in_ready = !flush && (!out_valid || out_ready) && !hazard.
REQ-017 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid when out_ready && out_valid && no new input is accepted.
REQ-019 SHALL define hazard as HAZARD_EN && out_valid && registered op==LW && rt!=0 && (incoming rs==rt || (incoming reads rt && incoming rt==rt)).
REQ-020 SHALL treat rt as read only for R-type, SW, BEQ and BNE.
REQ-021 SHALL, on hazard with out_ready=1, retire the LW and register a bubble (out_valid=0), then accept the dependent instruction on the next cycle: exactly one bubble.
REQ-022 SHALL increment bubble_count once per inserted bubble, saturating at all-ones.
REQ-023 SHALL, on flush, clear out_valid and hold in_ready=0 that cycle; flush overrides acceptance and hazard.
REQ-024 SHALL leave hazard inactive when out_valid=0 or HAZARD_EN=0.

Reset
REQ-025 SHALL, on reset, zero out_valid, all field and control outputs, and bubble_count.
REQ-026 SHALL drive in_ready=0 during reset.
REQ-027 SHALL give reset priority over flush and handshakes.
REQ-028 SHALL discard any instruction held mid-handshake when reset is asserted; no replay.

Structure
REQ-029 SHALL place opcode/funct constants, alu_ctrl encodings (ADD, SUB, XOR, SLT) and reg_dst encodings in shared package mips_pkg.
REQ-030 SHALL implement opcode/funct-to-control as combinational sub-module decode_ctrl; pipelined_decode holds registers, handshake, hazard logic and counter.

Verification
REQ-031 SHALL test: ADDI 0x2008FFFF, out_ready=1 -> next cycle op=0x08, rt=8, imm_ext=0xFFFFFFFF, reg_write=1, alu_src=1, reg_dst=0.
REQ-032 SHALL test: LW 0x8C090000 then ADD 0x01295020 back-to-back -> one cycle out_valid=0 between them; bubble_count=1.
REQ-033 SHALL test: LW to r0 then ADD reading r0 -> no bubble; bubble_count unchanged.
REQ-034 SHALL test: out_ready=0 for 3 cycles with JAL 0x0C000010 registered -> outputs stable, in_ready=0; jump=1, jump_link=1, reg_dst=2, addr=0x10.
REQ-035 SHALL test: flush with valid BEQ registered -> next cycle out_valid=0, bubble_count unchanged.
REQ-036 SHALL test: op 0x3F -> illegal=1, reg_write=0, mem_write=0; reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, functs, ALU and destination encodings, control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic       jump_link;
    logic       jump_reg;
    logic       illegal;
  } ctrl_t;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode/funct to control-bundle decoder; unknown encodings flag illegal only.
module decode_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            ctrl_c.reg_dst   = REG_DST_RD;
            ctrl_c.reg_write = 1'b1;
            ctrl_c.alu_ctrl  = ALU_ADD;
          end
          FN_SUB: begin
            ctrl_c.reg_dst   = REG_DST_RD;
            ctrl_c.reg_write = 1'b1;
            ctrl_c.alu_ctrl  = ALU_SUB;
          end
          FN_SLT: begin
            ctrl_c.reg_dst   = REG_DST_RD;
            ctrl_c.reg_write = 1'b1;
            ctrl_c.alu_ctrl  = ALU_SLT;
          end
          FN_JR:   ctrl_c.jump_reg = 1'b1;
          default: ctrl_c.illegal  = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.alu_ctrl   = ALU_ADD;
        ctrl_c.reg_dst    = REG_DST_RT;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_ctrl  = ALU_ADD;
        ctrl_c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.alu_ctrl  = ALU_SUB;
        ctrl_c.branch_eq = 1'b1;
      end
      OP_BNE: begin
        ctrl_c.alu_ctrl  = ALU_SUB;
        ctrl_c.branch_ne = 1'b1;
      end
      OP_ADDI: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_ctrl  = ALU_ADD;
        ctrl_c.reg_dst   = REG_DST_RT;
        ctrl_c.reg_write = 1'b1;
      end
      OP_XORI: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_ctrl  = ALU_XOR;
        ctrl_c.reg_write = 1'b1;
      end
      OP_J:    ctrl_c.jump = 1'b1;
      OP_JAL: begin
        ctrl_c.jump      = 1'b1;
        ctrl_c.jump_link = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = REG_DST_R31;
      end
      default: ctrl_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_decode.sv
// Decode stage: one output register with valid/ready handshake, flush, and load-use bubble insertion.
module pipelined_decode
  import mips_pkg::*;
#(
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned REG_AW    = 5,
  parameter bit          HAZARD_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [INSTR_W-1:0] pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         op,
  output logic [5:0]         funct,
  output logic [REG_AW-1:0]  rs,
  output logic [REG_AW-1:0]  rt,
  output logic [REG_AW-1:0]  rd,
  output logic [15:0]        imm,
  output logic [INSTR_W-1:0] imm_ext,
  output logic [25:0]        addr,
  output logic [INSTR_W-1:0] pc_out,
  output logic               alu_src,
  output logic [2:0]         alu_ctrl,
  output logic [1:0]         reg_dst,
  output logic               reg_write,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               branch_eq,
  output logic               branch_ne,
  output logic               jump,
  output logic               jump_link,
  output logic               jump_reg,
  output logic               illegal,
  output logic [CNT_W-1:0]   bubble_count
);

  localparam int unsigned EXT_W = INSTR_W - 16;

  logic [5:0]        in_op, in_funct;
  logic [REG_AW-1:0] in_rs, in_rt, in_rd;
  ctrl_t             in_ctrl;
  logic              hazard_c, accept_c, bubble_c;

  logic               out_valid_q, out_valid_d;
  logic [5:0]         op_q, op_d, funct_q, funct_d;
  logic [REG_AW-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [15:0]        imm_q, imm_d;
  logic [INSTR_W-1:0] imm_ext_q, imm_ext_d, pc_q, pc_d;
  logic [25:0]        addr_q, addr_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   bubble_count_q, bubble_count_d;

  assign in_op    = instr[31:26];
  assign in_funct = instr[5:0];
  assign in_rs    = REG_AW'(instr[25:21]);
  assign in_rt    = REG_AW'(instr[20:16]);
  assign in_rd    = REG_AW'(instr[15:11]);

  decode_ctrl u_decode_ctrl (
    .op     (in_op),
    .funct  (in_funct),
    .ctrl_c (in_ctrl)
  );

  // A load writing a nonzero rt stalls any consumer of that register for one cycle.
  always_comb begin
    hazard_c = HAZARD_EN && out_valid_q && (op_q == OP_LW) && (rt_q != '0) &&
               ((in_rs == rt_q) || (reads_rt(in_op) && (in_rt == rt_q)));
    in_ready = !reset && !flush && (!out_valid_q || out_ready) && !hazard_c;
    accept_c = in_valid && in_ready;
    bubble_c = in_valid && hazard_c && out_ready && !flush;
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    op_d           = op_q;
    funct_d        = funct_q;
    rs_d           = rs_q;
    rt_d           = rt_q;
    rd_d           = rd_q;
    imm_d          = imm_q;
    imm_ext_d      = imm_ext_q;
    addr_d         = addr_q;
    pc_d           = pc_q;
    ctrl_d         = ctrl_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_c) begin
      out_valid_d = 1'b1;
      op_d        = in_op;
      funct_d     = in_funct;
      rs_d        = in_rs;
      rt_d        = in_rt;
      rd_d        = in_rd;
      imm_d       = instr[15:0];
      imm_ext_d   = {{EXT_W{instr[15]}}, instr[15:0]};
      addr_d      = instr[25:0];
      pc_d        = pc;
      ctrl_d      = in_ctrl;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bubble_c && (bubble_count_q != '1)) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      op_q           <= '0;
      funct_q        <= '0;
      rs_q           <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
      imm_q          <= '0;
      imm_ext_q      <= '0;
      addr_q         <= '0;
      pc_q           <= '0;
      ctrl_q         <= '0;
      bubble_count_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      op_q           <= op_d;
      funct_q        <= funct_d;
      rs_q           <= rs_d;
      rt_q           <= rt_d;
      rd_q           <= rd_d;
      imm_q          <= imm_d;
      imm_ext_q      <= imm_ext_d;
      addr_q         <= addr_d;
      pc_q           <= pc_d;
      ctrl_q         <= ctrl_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign op           = op_q;
  assign funct        = funct_q;
  assign rs           = rs_q;
  assign rt           = rt_q;
  assign rd           = rd_q;
  assign imm          = imm_q;
  assign imm_ext      = imm_ext_q;
  assign addr         = addr_q;
  assign pc_out       = pc_q;
  assign alu_src      = ctrl_q.alu_src;
  assign alu_ctrl     = ctrl_q.alu_ctrl;
  assign reg_dst      = ctrl_q.reg_dst;
  assign reg_write    = ctrl_q.reg_write;
  assign mem_write    = ctrl_q.mem_write;
  assign mem_to_reg   = ctrl_q.mem_to_reg;
  assign branch_eq    = ctrl_q.branch_eq;
  assign branch_ne    = ctrl_q.branch_ne;
  assign jump         = ctrl_q.jump;
  assign jump_link    = ctrl_q.jump_link;
  assign jump_reg     = ctrl_q.jump_reg;
  assign illegal      = ctrl_q.illegal;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_pipelined_decode.sv
// Scoreboard bench for pipelined_decode: reference decode model plus directed hazard/stall/flush/reset cases.
module tb_pipelined_decode;
  import mips_pkg::*;

  logic        clk, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, imm_ext, pc_out;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] addr;
  logic        alu_src, reg_write, mem_write, mem_to_reg, branch_eq, branch_ne;
  logic        jump, jump_link, jump_reg, illegal;
  logic [2:0]  alu_ctrl;
  logic [1:0]  reg_dst;
  logic [15:0] bubble_count;
  logic [14:0] obs_ctl;

  pipelined_decode #(.INSTR_W(32), .REG_AW(5), .HAZARD_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op(op), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .imm_ext(imm_ext), .addr(addr), .pc_out(pc_out),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .jump(jump), .jump_link(jump_link), .jump_reg(jump_reg), .illegal(illegal),
    .bubble_count(bubble_count)
  );

  assign obs_ctl = {alu_src, alu_ctrl, reg_dst, reg_write, mem_write, mem_to_reg,
                    branch_eq, branch_ne, jump, jump_link, jump_reg, illegal};

  typedef struct packed {
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;
    logic [25:0] addr;
    logic [31:0] pc;
    logic [14:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference control table, packed in the same order as obs_ctl.
  function automatic logic [14:0] ref_ctl(input logic [31:0] i);
    logic       src, rw, mw, m2r, beq, bne, j, jl, jr, ill;
    logic [2:0] alu;
    logic [1:0] dst;
    {src, rw, mw, m2r, beq, bne, j, jl, jr, ill} = '0;
    alu = ALU_ADD;
    dst = REG_DST_RT;
    case (i[31:26])
      6'h00: case (i[5:0])
               6'h20: begin dst = REG_DST_RD; rw = 1; end
               6'h22: begin dst = REG_DST_RD; rw = 1; alu = ALU_SUB; end
               6'h2A: begin dst = REG_DST_RD; rw = 1; alu = ALU_SLT; end
               6'h08: jr = 1;
               default: ill = 1;
             endcase
      6'h23: begin src = 1; rw = 1; m2r = 1; end
      6'h2B: begin src = 1; mw = 1; end
      6'h04: begin alu = ALU_SUB; beq = 1; end
      6'h05: begin alu = ALU_SUB; bne = 1; end
      6'h08: begin src = 1; rw = 1; end
      6'h0E: begin src = 1; rw = 1; alu = ALU_XOR; end
      6'h02: j = 1;
      6'h03: begin j = 1; jl = 1; rw = 1; dst = REG_DST_R31; end
      default: ill = 1;
    endcase
    return {src, alu, dst, rw, mw, m2r, beq, bne, j, jl, jr, ill};
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    e.op      = i[31:26];
    e.funct   = i[5:0];
    e.rs      = i[25:21];
    e.rt      = i[20:16];
    e.rd      = i[15:11];
    e.imm_ext = {{16{i[15]}}, i[15:0]};
    e.addr    = i[25:0];
    e.pc      = p;
    e.ctl     = ref_ctl(i);
    return e;
  endfunction

  // Every completed output handshake is checked against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_op", op, e.op);
        check_eq("sb_funct", funct, e.funct);
        check_eq("sb_rs", rs, e.rs);
        check_eq("sb_rt", rt, e.rt);
        check_eq("sb_rd", rd, e.rd);
        check_eq("sb_imm", imm, e.imm_ext[15:0]);
        check_eq("sb_imm_ext", imm_ext, e.imm_ext);
        check_eq("sb_addr", addr, e.addr);
        check_eq("sb_pc", pc_out, e.pc);
        check_eq("sb_ctl", obs_ctl, e.ctl);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction until accepted; returns how many cycles it was held off.
  task automatic send(input logic [31:0] i, input logic [31:0] p, input bit expect_out,
                      output int stalls);
    bit acc;
    instr = i; pc = p; in_valid = 1'b1; stalls = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      acc = in_ready;
      tick();
      if (acc) begin
        if (expect_out) sb.push_back(model(i, p));
        in_valid = 1'b0;
        return;
      end
      stalls++;
    end
    check_eq("send_timeout", 64'(stalls), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          st;
    logic [46:0] snap_a;
    logic [31:0] snap_pc;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = '0; pc = '0;
    tick(); tick();
    check_eq("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_bubble", bubble_count, 16'd0);
    check_eq("rst_ctl", obs_ctl, 15'd0);
    check_eq("rst_imm_ext", imm_ext, 32'd0);
    check_eq("idle_in_ready", in_ready, 1'b1);

    // ADDI with negative immediate
    send(32'h2008FFFF, 32'h100, 1'b1, st);
    check_eq("addi_valid", out_valid, 1'b1);
    check_eq("addi_op", op, 6'h08);
    check_eq("addi_rt", rt, 5'd8);
    check_eq("addi_imm_ext", imm_ext, 32'hFFFFFFFF);
    check_eq("addi_reg_write", reg_write, 1'b1);
    check_eq("addi_alu_src", alu_src, 1'b1);
    check_eq("addi_reg_dst", reg_dst, 2'd0);
    tick();

    // LW r9 followed by ADD reading r9: exactly one bubble
    send(32'h8C090000, 32'h104, 1'b1, st);
    instr = 32'h01295020; pc = 32'h108; in_valid = 1'b1;
    #1;
    check_eq("lu_in_ready_hazard", in_ready, 1'b0);
    tick();
    check_eq("lu_bubble_valid", out_valid, 1'b0);
    check_eq("lu_bubble_count", bubble_count, 16'd1);
    #1;
    check_eq("lu_in_ready_after", in_ready, 1'b1);
    tick();
    sb.push_back(model(32'h01295020, 32'h108));
    in_valid = 1'b0;
    check_eq("lu_add_valid", out_valid, 1'b1);
    check_eq("lu_add_rd", rd, 5'd10);
    tick();

    // LW to r0 never stalls
    send(32'h8D200000, 32'h10C, 1'b1, st);
    send(32'h00005020, 32'h110, 1'b1, st);
    check_eq("r0_stalls", 64'(st), 64'd0);
    check_eq("r0_bubble", bubble_count, 16'd1);

    // XORI's rt is a destination, so matching it is not a hazard
    send(32'h8C090000, 32'h114, 1'b1, st);
    send(32'h39490005, 32'h118, 1'b1, st);
    check_eq("xori_stalls", 64'(st), 64'd0);
    check_eq("xori_bubble", bubble_count, 16'd1);

    // SW reads rt, so matching it is a hazard
    send(32'h8C090000, 32'h11C, 1'b1, st);
    send(32'hAD490004, 32'h120, 1'b1, st);
    check_eq("sw_stalls", 64'(st), 64'd1);
    check_eq("sw_bubble", bubble_count, 16'd2);
    tick(); tick();

    // JAL held under backpressure for three cycles
    out_ready = 1'b0;
    send(32'h0C000010, 32'h200, 1'b1, st);
    instr = 32'h2008FFFF; pc = 32'h204; in_valid = 1'b1;
    snap_a = {addr, obs_ctl, op};
    snap_pc = pc_out;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_valid", out_valid, 1'b1);
      check_eq("bp_stable", {addr, obs_ctl, op}, snap_a);
      check_eq("bp_pc_stable", pc_out, snap_pc);
      tick();
    end
    check_eq("jal_jump", jump, 1'b1);
    check_eq("jal_link", jump_link, 1'b1);
    check_eq("jal_reg_dst", reg_dst, 2'd2);
    check_eq("jal_addr", addr, 26'h10);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    // Flush discards a registered BEQ and blocks acceptance
    out_ready = 1'b0;
    send(32'h112A0008, 32'h300, 1'b0, st);
    check_eq("beq_branch_eq", branch_eq, 1'b1);
    flush = 1'b1; instr = 32'h2008FFFF; in_valid = 1'b1;
    #1;
    check_eq("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_bubble", bubble_count, 16'd2);
    out_ready = 1'b1;
    tick();

    // Unknown opcode
    send(32'hFC000000, 32'h400, 1'b1, st);
    check_eq("ill_illegal", illegal, 1'b1);
    check_eq("ill_reg_write", reg_write, 1'b0);
    check_eq("ill_mem_write", mem_write, 1'b0);
    tick();

    // Reset while an instruction is held
    out_ready = 1'b0;
    send(32'h2008FFFF, 32'h500, 1'b0, st);
    check_eq("pre_rst_valid", out_valid, 1'b1);
    reset = 1'b1; instr = 32'h01295020; in_valid = 1'b1;
    tick();
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_op", op, 6'h00);
    check_eq("mid_rst_rt", rt, 5'd0);
    check_eq("mid_rst_imm_ext", imm_ext, 32'd0);
    check_eq("mid_rst_pc", pc_out, 32'd0);
    check_eq("mid_rst_ctl", obs_ctl, 15'd0);
    check_eq("mid_rst_bubble", bubble_count, 16'd0);
    check_eq("mid_rst_in_ready", in_ready, 1'b0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    send(32'h0128502A, 32'h600, 1'b1, st);
    tick(); tick();
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
